// File: rtl/online_ccm_share_sched.sv
// ---------------------------------------------------------------------------
// online_ccm_share_sched
//
// Time-shares one combinational constant-coefficient multiplier (CCM) among
// NREQ requesters. A round-robin arbiter picks one valid requester, registers
// its operand onto ccm_x, waits a programmable number of cycles for the CCM
// output to settle, captures the result and presents it on a valid/ready
// response port tagged with the owning requester index.
//
// Ports
//   clk, rst       : clock; synchronous active-high reset
//   req_valid      : [NREQ]      per-requester operand valid
//   req_data       : [NREQ*WL]   operands, requester i at [i*WL +: WL]
//   req_ready      : [NREQ]      one-hot grant, only ever high in IDLE
//   settle_cycles  : [SET_W]     settle budget, sampled at grant (0 acts as 1)
//   ccm_x          : [WL]        registered operand driven to the CCM
//   ccm_y          : [OUT_W]     CCM result
//   rsp_valid/rsp_ready          response handshake
//   rsp_data       : [OUT_W]     captured CCM result
//   rsp_id         : [3]         requester that owns rsp_data
//   busy           : high whenever not IDLE
// ---------------------------------------------------------------------------
module online_ccm_share_sched #(
    parameter int Stage = 4,
    parameter int OUT_W = 2*(Stage+9),
    parameter int NREQ  = 4,
    parameter int SET_W = 4,
    localparam int WL   = 2*Stage
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*WL-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic [SET_W-1:0]     settle_cycles,
    output logic [WL-1:0]        ccm_x,
    input  logic [OUT_W-1:0]     ccm_y,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [OUT_W-1:0]     rsp_data,
    output logic [2:0]           rsp_id,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [SET_W-1:0] cnt;
    logic [2:0]       last_grant;

    logic             gnt_vld;
    logic [2:0]       gnt_idx;
    logic [7:0]       vld_pad;
    logic [3:0]       idx;
    logic             fire;

    // Round-robin pick: scan from last_grant+1 upward, wrapping at NREQ.
    // last_grant < NREQ and k <= NREQ, so one conditional subtract is a
    // complete modulo. req_valid is padded to 8 bits so a 3-bit index is
    // always in range regardless of NREQ.
    always_comb begin
        vld_pad = 8'(req_valid);
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = {1'b0, last_grant} + 4'(k);
            if (idx >= 4'(NREQ))
                idx = idx - 4'(NREQ);
            if (!gnt_vld && vld_pad[idx[2:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx[2:0];
            end
        end
    end

    // Handshake: the winner is by construction valid, so its ready is the
    // whole condition.
    assign fire = (state == IDLE) && gnt_vld;

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic. RESP always falls back to IDLE before the next
    // grant, so there is no response-to-grant bypass.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fire)                    state_nxt = SETTLE;
            SETTLE:  if (cnt == SET_W'(1))        state_nxt = RESP;
            RESP:    if (rsp_ready)               state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = '0;
        if (fire)
            req_ready = NREQ'(1) << gnt_idx;
        busy      = (state != IDLE);
        rsp_valid = (state == RESP);
    end

    // Datapath. settle_cycles is only looked at on the grant edge, so the
    // operation in flight is immune to later changes. ccm_x is held until
    // the next grant, so the CCM input stays stable for the full count.
    always_ff @(posedge clk) begin
        if (rst) begin
            ccm_x      <= '0;
            rsp_data   <= '0;
            rsp_id     <= '0;
            cnt        <= '0;
            last_grant <= 3'(NREQ-1);
        end else begin
            if (fire) begin
                ccm_x      <= req_data[gnt_idx*WL +: WL];
                rsp_id     <= gnt_idx;
                last_grant <= gnt_idx;
                cnt        <= (settle_cycles == '0) ? SET_W'(1) : settle_cycles;
            end else if (state == SETTLE) begin
                cnt <= cnt - SET_W'(1);
                if (cnt == SET_W'(1))
                    rsp_data <= ccm_y;
            end
        end
    end

endmodule

// File: tb/tb_online_ccm_share_sched.sv
// ---------------------------------------------------------------------------
// Bench for online_ccm_share_sched. A stub CCM returns the operand only once
// ccm_x has held for three cycles (all ones otherwise), so capture timing is
// observable in the data. A round-robin model picks winners from the request
// mask and the last grant; each op is followed cycle by cycle.
// Inputs are driven just after the falling edge, outputs sampled 1ns later.
// ---------------------------------------------------------------------------
module tb_online_ccm_share_sched;
    localparam int Stage = 4;
    localparam int WL    = 2*Stage;
    localparam int OUT_W = 2*(Stage+9);
    localparam int NREQ  = 4;
    localparam int SET_W = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*WL-1:0]  req_data = '0;
    logic [NREQ-1:0]     req_ready;
    logic [SET_W-1:0]    settle_cycles = '0;
    logic [WL-1:0]       ccm_x;
    logic [OUT_W-1:0]    ccm_y;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [OUT_W-1:0]    rsp_data;
    logic [2:0]          rsp_id;
    logic                busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model state
    int          m_last = NREQ-1;
    logic [WL-1:0] m_x = '0;

    // stub CCM stability tracker
    logic [WL-1:0] last_x = '0;
    int            stab = 0;

    online_ccm_share_sched #(.Stage(Stage), .OUT_W(OUT_W), .NREQ(NREQ), .SET_W(SET_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .settle_cycles(settle_cycles),
        .ccm_x(ccm_x), .ccm_y(ccm_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ccm_x !== last_x) begin
            last_x <= ccm_x;
            stab   <= 1;
        end else if (stab < 1000) begin
            stab <= stab + 1;
        end
    end

    assign ccm_y = (stab >= 3) ? OUT_W'(ccm_x) : '1;

    function automatic int rr_pick(input logic [NREQ-1:0] m, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last + k) % NREQ;
            if (m[i]) return i;
        end
        return 0;
    endfunction

    // every lane differs from the operand currently on ccm_x
    function automatic logic [NREQ*WL-1:0] gen_data();
        logic [NREQ*WL-1:0] d;
        d = '0;
        for (int i = 0; i < NREQ; i++) begin
            logic [WL-1:0] v;
            v = WL'($urandom);
            if (v == m_x) v = ~v;
            d[i*WL +: WL] = v;
        end
        return d;
    endfunction

    // Starts just after a falling edge with the DUT in IDLE; returns just
    // after the falling edge of the first IDLE cycle after the response.
    task automatic run_op(input logic [NREQ-1:0] mask, input logic [NREQ*WL-1:0] dat,
                          input logic [SET_W-1:0] s, input int hold, input bit keep,
                          output logic [OUT_W-1:0] rd, output logic [2:0] rid);
        int               g, n;
        logic [OUT_W-1:0] exp_d;
        logic [NREQ-1:0]  exp_rdy;
        req_valid     = mask;
        req_data      = dat;
        settle_cycles = s;
        rsp_ready     = 1'($urandom);
        #1;
        g       = rr_pick(mask, m_last);
        exp_rdy = NREQ'(1) << g;
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL grant: req_ready=%b expected %b", req_ready, exp_rdy);
        end
        n      = (s == '0) ? 1 : int'(s);
        m_last = g;
        m_x    = dat[g*WL +: WL];
        exp_d  = (n >= 3) ? OUT_W'(m_x) : '1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            settle_cycles = SET_W'($urandom);
            rsp_ready     = 1'($urandom);
            if (!keep) req_valid = NREQ'($urandom);
            #1;
            checks++;
            if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== '0 || ccm_x !== m_x) begin
                errors++;
                $display("FAIL settle[%0d]: busy=%b rsp_valid=%b req_ready=%b ccm_x=%h expected 1 0 0 %h",
                         i, busy, rsp_valid, req_ready, ccm_x, m_x);
            end
        end
        @(negedge clk);
        rsp_ready = (hold == 0);
        if (!keep) req_valid = NREQ'($urandom);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rsp_timing: rsp_valid=%b busy=%b expected 1 1", rsp_valid, busy);
        end
        checks++;
        if (rsp_data !== exp_d) begin
            errors++;
            $display("FAIL rsp_data: got %h expected %h", rsp_data, exp_d);
        end
        checks++;
        if (rsp_id !== 3'(g)) begin
            errors++;
            $display("FAIL rsp_id: got %0d expected %0d", rsp_id, g);
        end
        rd  = rsp_data;
        rid = rsp_id;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            rsp_ready = (h == hold-1);
            if (!keep) req_valid = NREQ'($urandom);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_id !== 3'(g) ||
                busy !== 1'b1 || req_ready !== '0) begin
                errors++;
                $display("FAIL hold[%0d]: rsp_valid=%b data=%h id=%0d busy=%b req_ready=%b expected 1 %h %0d 1 0",
                         h, rsp_valid, rsp_data, rsp_id, busy, req_ready, exp_d, g);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        if (!keep) req_valid = '0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || ccm_x !== m_x) begin
            errors++;
            $display("FAIL release: busy=%b rsp_valid=%b ccm_x=%h expected 0 0 %h",
                     busy, rsp_valid, ccm_x, m_x);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        m_last = NREQ-1;
        m_x    = '0;
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b rsp_valid=%b req_ready=%b expected 0 0 0", busy, rsp_valid, req_ready);
        end
        checks++;
        if (ccm_x !== '0 || rsp_data !== '0 || rsp_id !== '0) begin
            errors++;
            $display("FAIL reset_data: ccm_x=%h rsp_data=%h rsp_id=%0d expected 0 0 0", ccm_x, rsp_data, rsp_id);
        end
        @(negedge clk);
        rst    = 1'b0;
        m_last = NREQ-1;
        m_x    = '0;
        #1;
    endtask

    task automatic test_basic();
        logic [NREQ*WL-1:0] d;
        logic [OUT_W-1:0]   rd;
        logic [2:0]         rid;
        d = gen_data();
        d[7:0] = 8'h5A;
        run_op(4'b0001, d, 4'd3, 0, 1'b0, rd, rid);
        checks++;
        if (rd !== 26'h000005A || rid !== 3'd0) begin
            errors++;
            $display("FAIL basic: rsp_data=%h rsp_id=%0d expected 000005a 0", rd, rid);
        end
    endtask

    task automatic test_short_settle();
        logic [OUT_W-1:0] rd;
        logic [2:0]       rid;
        run_op(4'b0010, gen_data(), 4'd2, 0, 1'b0, rd, rid);
        checks++;
        if (rd !== 26'h3FFFFFF) begin
            errors++;
            $display("FAIL short_settle: rsp_data=%h expected 3ffffff", rd);
        end
    endtask

    task automatic test_zero_settle();
        logic [OUT_W-1:0] rd;
        logic [2:0]       rid;
        run_op(4'b1000, gen_data(), 4'd0, 0, 1'b0, rd, rid);
        checks++;
        if (rd !== 26'h3FFFFFF || rid !== 3'd3) begin
            errors++;
            $display("FAIL zero_settle: rsp_data=%h rsp_id=%0d expected 3ffffff 3", rd, rid);
        end
    endtask

    task automatic test_hold();
        logic [OUT_W-1:0] rd;
        logic [2:0]       rid;
        run_op(4'b0110, gen_data(), 4'd4, 5, 1'b0, rd, rid);
    endtask

    task automatic test_deassert();
        logic [NREQ-1:0] exp_rdy;
        logic [WL-1:0]   x0;
        x0        = m_x;
        req_valid = 4'b0100;
        req_data  = gen_data();
        #1;
        exp_rdy = NREQ'(1) << rr_pick(4'b0100, m_last);
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL deassert_offer: req_ready=%b expected %b", req_ready, exp_rdy);
        end
        #1;
        req_valid = '0;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || ccm_x !== x0 || req_ready !== '0) begin
            errors++;
            $display("FAIL deassert: busy=%b ccm_x=%h req_ready=%b expected 0 %h 0", busy, ccm_x, req_ready, x0);
        end
    endtask

    task automatic test_fairness();
        logic [OUT_W-1:0] rd;
        logic [2:0]       rid;
        logic [2:0]       exp_ids [5];
        exp_ids = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_op('1, gen_data(), 4'd3, 0, 1'b1, rd, rid);
            checks++;
            if (rid !== exp_ids[i]) begin
                errors++;
                $display("FAIL fairness[%0d]: rsp_id=%0d expected %0d", i, rid, exp_ids[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [NREQ-1:0]  exp_rdy;
        logic [OUT_W-1:0] rd;
        logic [2:0]       rid;
        req_valid     = 4'b0010;
        req_data      = gen_data();
        settle_cycles = 4'd6;
        #1;
        exp_rdy = NREQ'(1) << rr_pick(4'b0010, m_last);
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL midrst_grant: req_ready=%b expected %b", req_ready, exp_rdy);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        m_last = NREQ-1;
        m_x    = '0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || ccm_x !== '0 || rsp_data !== '0 ||
            rsp_id !== '0 || req_ready !== '0) begin
            errors++;
            $display("FAIL midrst: busy=%b rsp_valid=%b ccm_x=%h rsp_data=%h rsp_id=%0d req_ready=%b expected all 0",
                     busy, rsp_valid, ccm_x, rsp_data, rsp_id, req_ready);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midrst_quiet[%0d]: rsp_valid=%b busy=%b expected 0 0", i, rsp_valid, busy);
            end
        end
        run_op('1, gen_data(), 4'd3, 0, 1'b0, rd, rid);
        checks++;
        if (rid !== 3'd0) begin
            errors++;
            $display("FAIL midrst_next: rsp_id=%0d expected 0", rid);
        end
    endtask

    task automatic test_random();
        logic [OUT_W-1:0] rd;
        logic [2:0]       rid;
        logic [NREQ-1:0]  m;
        for (int i = 0; i < 40; i++) begin
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            run_op(m, gen_data(), SET_W'($urandom_range(0, 7)), $urandom_range(0, 3), 1'b0, rd, rid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_settle();
        test_zero_settle();
        test_hold();
        test_deassert();
        test_fairness();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/online_ccm_share_sched.md
ONLINE_CCM_SHARE_SCHED -- requirements
Module: online_ccm_share_sched

Interface
REQ-001 Parameter Stage, default 4, sets the operand digit count; operand width WL = 2*Stage bits (2-bit signed-digit encoding).
REQ-002 Parameter OUT_W, default 2*(Stage+9), sets the CCM result width.
REQ-003 Parameter NREQ, default 4, sets the requester count (2..8).
REQ-004 Parameter SET_W, default 4, sets the settle-count width.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 req_valid  input  NREQ  per-requester operand valid.
REQ-008 req_data  input  NREQ*WL  operands; requester i occupies bits [i*WL +: WL].
REQ-009 req_ready  output  NREQ  one-hot grant/accept; at most one bit high.
REQ-010 settle_cycles  input  SET_W  cycles allowed for the combinational CCM to settle.
REQ-011 ccm_x  output  WL  registered operand driven to the shared CCM.
REQ-012 ccm_y  input  OUT_W  CCM result.
REQ-013 rsp_valid  output  1  result valid.
REQ-014 rsp_ready  input  1  result accepted.
REQ-015 rsp_data  output  OUT_W  captured result.
REQ-016 rsp_id  output  3  index of the requester that owns rsp_data.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, SETTLE, and RESP, and no others.
REQ-019 In IDLE, if any req_valid bit is high, req_ready SHALL assert combinationally for exactly one winner, chosen round-robin starting at (last_grant+1) mod NREQ.
REQ-020 When req_valid[g] and req_ready[g] are both high in cycle T: ccm_x SHALL load req_data[g]; rsp_id SHALL load g; last_grant SHALL load g; cnt SHALL load N = max(settle_cycles,1); the FSM SHALL enter SETTLE.
REQ-021 settle_cycles SHALL be sampled only at the grant; later changes SHALL NOT affect the operation in flight.
REQ-022 In SETTLE, cnt SHALL decrement each cycle; on the edge where cnt==1, rsp_data SHALL load ccm_y and the FSM SHALL enter RESP.
REQ-023 Given REQ-022, ccm_x is stable for exactly N cycles (T+1..T+N) before capture, and rsp_valid SHALL rise at cycle T+N+1.
REQ-024 In RESP, rsp_valid SHALL be high, and rsp_data/rsp_id SHALL hold stable until the cycle in which rsp_ready is high; the FSM SHALL then return to IDLE.
REQ-025 The RESP-to-IDLE transition SHALL have no bypass: a new grant occurs no earlier than the first IDLE cycle, so minimum spacing between grants is N+2 cycles.
REQ-026 req_ready SHALL be all-zero outside IDLE.
REQ-027 ccm_x SHALL hold its last value through RESP and IDLE until the next grant.
REQ-028 A requester that deasserts req_valid before handshake SHALL NOT be granted, and no state SHALL change.
REQ-029 rsp_ready high while not in RESP SHALL be ignored.
REQ-030 Round-robin fairness: with all requesters continuously valid, grants SHALL cycle 0,1,..,NREQ-1,0,...

Reset
REQ-031 While rst is high at a clock edge, the next state SHALL be: state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, ccm_x=0, cnt=0, last_grant=NREQ-1 (requester 0 first), busy=0.
REQ-032 Reset asserted mid-operation (SETTLE or RESP) SHALL abandon the operation with no response produced; requesters must re-present their operands.

Verification (Stage=4, WL=8, OUT_W=26; stub CCM returns {18'b0,ccm_x} only after ccm_x has been stable for 3 cycles, otherwise 26'h3FFFFFF)
REQ-033 settle_cycles=3, req_valid=4'b0001, req_data[7:0]=8'h5A -> req_ready=4'b0001 at T; ccm_x=8'h5A at T+1; rsp_valid at T+4 with rsp_data=26'h000005A, rsp_id=0.
REQ-034 settle_cycles=2 with the same stub -> rsp_data=26'h3FFFFFF, proving that capture timing follows REQ-022.
REQ-035 All four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0, with grants spaced N+2 cycles apart.
REQ-036 settle_cycles=0 -> behaves exactly as settle_cycles=1 (rsp_valid at T+2).
REQ-037 rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_data, rsp_id stable, req_ready=0, busy=1 throughout; IDLE the cycle after rsp_ready rises.
REQ-038 rst pulsed during SETTLE -> next cycle all outputs zero, busy=0, no rsp_valid; next grant goes to requester 0.
